// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding,
// default geometry and digit-count helpers.
package seq_magnitude_comparator_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DIGIT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit index width; never narrower than one bit, even for a single digit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_cmp.sv
// Combinational DIGIT-bit unsigned comparator, scanning from the MSB the same
// way the original 4-bit gate comparator cascades its per-bit terms.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    logic eq_acc;
    logic gt_acc;
    logic lt_acc;

    // NOTE: blocking assignments are correct here; each loop pass must see the
    // running prefix value produced by the previous (more significant) bit.
    always_comb begin
        eq_acc = 1'b1;
        gt_acc = 1'b0;
        lt_acc = 1'b0;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt_acc = gt_acc | (eq_acc &  a[i] & ~b[i]);
            lt_acc = lt_acc | (eq_acc & ~a[i] &  b[i]);
            eq_acc = eq_acc & ~(a[i] ^ b[i]);
        end
    end

    assign lt = lt_acc;
    assign gt = gt_acc;
    assign eq = eq_acc;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Serial magnitude comparator: checks DIGIT bits per clock from the MSB digit
// down and finishes at the first digit that differs. WIDTH must be a multiple of DIGIT.
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIGIT = DEFAULT_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_lt_B,
    output logic             A_gt_B,
    output logic             A_eq_B
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IDXW = idx_width(NDIG);
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NDIG - 1);

    state_t state;
    state_t next_state;

    logic [NDIG-1:0][DIGIT-1:0] a_q;
    logic [NDIG-1:0][DIGIT-1:0] b_q;
    logic [IDXW-1:0]            idx;
    logic                       accept;
    logic                       d_lt;
    logic                       d_gt;
    logic                       d_eq;

    assign accept = (state == ST_IDLE) && start;

    // Signed order becomes unsigned order once the sign bit is flipped
    // (offset binary), so the mapping is folded into the operand latch.
    // NOTE: operand registers carry no reset; they are only read in ST_CMP,
    // which is always entered through a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= A ^ {signed_mode, {(WIDTH-1){1'b0}}};
            b_q <= B ^ {signed_mode, {(WIDTH-1){1'b0}}};
        end
    end

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .lt (d_lt),
        .gt (d_gt),
        .eq (d_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state takes a default first so no path through the case
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_CMP;
            ST_CMP:  if (!d_eq || idx == '0) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_CMP);
    end

    // Index counter and result registers; flags change only alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            done   <= 1'b0;
            A_lt_B <= 1'b0;
            A_gt_B <= 1'b0;
            A_eq_B <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx <= IDX_MSB;
            end else if (state == ST_CMP) begin
                if (!d_eq) begin
                    done   <= 1'b1;
                    A_lt_B <= d_lt;
                    A_gt_B <= d_gt;
                    A_eq_B <= 1'b0;
                end else if (idx == '0) begin
                    done   <= 1'b1;
                    A_lt_B <= 1'b0;
                    A_gt_B <= 1'b0;
                    A_eq_B <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4): latency,
// flags, busy/done handshake, ignored start, async reset and back-to-back.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic        A_lt_B;
    logic        A_gt_B;
    logic        A_eq_B;

    int n_checks = 0;
    int n_errs   = 0;

    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .A_lt_B      (A_lt_B),
        .A_gt_B      (A_gt_B),
        .A_eq_B      (A_eq_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {A_lt_B, A_gt_B, A_eq_B};
    endfunction

    // Called just after a rising edge; returns just after the edge that samples start.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
        start       = 1'b1;
        A           = a;
        B           = b;
        signed_mode = s;
        @(posedge clk);
        #1;
        start       = 1'b0;
        A           = 16'($urandom);
        B           = 16'($urandom);
        signed_mode = 1'($urandom);
    endtask

    // Counts edges until done (bounded); also counts cycles with busy high.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 0;
        busy_cycles = 0;
        while (lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    int lat;
    int bc;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        #12;
        check("reset_outputs", {27'd0, busy, done, flags()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: equal operands take all four digits
        issue(16'h1234, 16'h1234, 1'b0);
        wait_done(lat, bc);
        check("eq_latency", lat, 4);
        check("eq_flags", {29'd0, flags()}, {29'd0, F_EQ});
        check("eq_busy_cycles", bc, 4);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("flags_held", {29'd0, flags()}, {29'd0, F_EQ});

        // 2: third digit differs, both orders
        issue(16'h12F4, 16'h1254, 1'b0);
        wait_done(lat, bc);
        check("d3_gt_latency", lat, 3);
        check("d3_gt_flags", {29'd0, flags()}, {29'd0, F_GT});
        issue(16'h1254, 16'h12F4, 1'b0);
        wait_done(lat, bc);
        check("d3_lt_latency", lat, 3);
        check("d3_lt_flags", {29'd0, flags()}, {29'd0, F_LT});

        // 3: sign handling
        issue(16'h8000, 16'h7FFF, 1'b0);
        wait_done(lat, bc);
        check("uns_msb_latency", lat, 1);
        check("uns_msb_flags", {29'd0, flags()}, {29'd0, F_GT});
        issue(16'h8000, 16'h7FFF, 1'b1);
        wait_done(lat, bc);
        check("sgn_msb_latency", lat, 1);
        check("sgn_msb_flags", {29'd0, flags()}, {29'd0, F_LT});
        issue(16'hFFFF, 16'hFFFE, 1'b1);
        wait_done(lat, bc);
        check("sgn_neg_latency", lat, 4);
        check("sgn_neg_flags", {29'd0, flags()}, {29'd0, F_GT});

        // 4: start while busy is ignored
        issue(16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        start       = 1'b1;
        A           = 16'hFFFF;
        B           = 16'h0000;
        signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("ignore_rem_latency", lat, 2);
        check("ignore_flags", {29'd0, flags()}, {29'd0, F_EQ});
        @(posedge clk);
        #1;
        check("ignore_no_restart", {30'd0, busy, done}, 32'd0);

        // 5: asynchronous reset mid-compare
        issue(16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", {27'd0, busy, done, flags()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_reset_idle", {27'd0, busy, done, flags()}, 32'd0);
        issue(16'h0005, 16'h0009, 1'b0);
        wait_done(lat, bc);
        check("post_reset_latency", lat, 4);
        check("post_reset_flags", {29'd0, flags()}, {29'd0, F_LT});

        // 6: start accepted in the done cycle
        issue(16'h2000, 16'h1000, 1'b0);
        wait_done(lat, bc);
        check("b2b_first_latency", lat, 1);
        check("b2b_first_flags", {29'd0, flags()}, {29'd0, F_GT});
        issue(16'h0000, 16'h1000, 1'b0);
        check("b2b_accepted_busy", {30'd0, busy, done}, 32'd2);
        check("b2b_flags_held", {29'd0, flags()}, {29'd0, F_GT});
        wait_done(lat, bc);
        check("b2b_second_latency", lat, 1);
        check("b2b_second_flags", {29'd0, flags()}, {29'd0, F_LT});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected to have finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator. It compares two WIDTH-bit operands DIGIT bits per clock, starting at the most significant digit, and stops early at the first digit that differs. It supports unsigned and two's-complement signed modes and uses a start/busy/done handshake. It replaces the fixed 4-bit combinational comparator in datapaths where WIDTH is large and the timing budget favours a serial compare.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT
DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT digits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
A  input  WIDTH  operand A; latched with start
B  input  WIDTH  operand B; latched with start
busy  output  1  comparison in progress
done  output  1  one-cycle pulse; result flags valid and updated this cycle
A_lt_B  output  1  result A<B; held until the next done
A_gt_B  output  1  result A>B; held until the next done
A_eq_B  output  1  result A==B; held until the next done

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, A_lt_B=0, A_gt_B=0, A_eq_B=0, FSM=IDLE, digit index=0.
- Reset mid-operation aborts the compare immediately. No done is issued and the flags are cleared.
- FSM states: IDLE and CMP.
  - IDLE -> CMP on start=1. Latch A, B and signed_mode. Set digit index to NDIG-1 (MSB digit). busy=1 from the next cycle.
  - CMP, digit differs: compare the current digit with the digit_cmp sub-module. Register A_lt_B/A_gt_B one-hot, A_eq_B=0, done=1, busy=0, then return to IDLE.
  - CMP, digit equal, index>0: decrement the index and stay in CMP.
  - CMP, digit equal, index=0: register A_eq_B=1 with lt=gt=0, done=1, busy=0, then return to IDLE.
- Signed mode: invert bit WIDTH-1 of both latched operands before comparing. This is offset-binary mapping, so an unsigned compare then gives the signed order. The mapping applies to the MSB digit only.
- Latency: number of rising edges from the edge that samples start to the edge that raises done.
  - Equals k, the 1-based position (from the MSB) of the first differing digit.
  - Equals NDIG when A==B.
  - Minimum 1, maximum NDIG.
- done is high for exactly one cycle. In that cycle busy=0.
- After the first done, exactly one flag is high. The flags hold their value until the next done, and only done updates them.
- start while busy=1 is ignored, with no effect on the latched operands or the state.
- start in the cycle where done=1 is accepted (busy is already 0), so back-to-back compares have no idle bubble.
- Operand inputs may change freely after the start edge; only latched copies are used.
- Both operands are treated as WIDTH bits; there is no sign extension beyond the signed_mode MSB mapping.

Decomposition:
- Shared header (comparator_defs.vh):
  - FSM state encodings ST_IDLE and ST_CMP.
  - Default WIDTH and DIGIT.
  - Macro NDIG(W,D) and the index-width macro (clog2 of NDIG, minimum 1).
- Sub-module digit_cmp: combinational, parameter DIGIT, inputs a[DIGIT-1:0] and b[DIGIT-1:0], outputs lt, gt, eq. It is the direct generalisation of the existing 4-bit gate comparator, and may be built structurally.
- Top level holds the FSM, operand registers, digit mux, index counter and result registers.

Test Plan (WIDTH=16, DIGIT=4):
1. Unsigned A=0x1234, B=0x1234 -> done after 4 edges, A_eq_B=1, lt=gt=0; busy high for 4 cycles.
2. Unsigned A=0x12F4, B=0x1254 -> digit 3 differs, done after 3 edges, A_gt_B=1. Swap the operands -> A_lt_B=1, latency 3.
3. A=0x8000, B=0x7FFF:
   - unsigned -> A_gt_B=1, latency 1;
   - signed_mode=1 -> A_lt_B=1, latency 1;
   - signed A=0xFFFF, B=0xFFFE -> A_gt_B=1, latency 4.
4. Start A=0x0001, B=0x0001. Pulse start with A=0xFFFF, B=0x0000 at edge 2 while busy -> ignored; result A_eq_B=1 at edge 4.
5. Assert rst_n=0 mid-compare (edge 2 of 4) -> busy, done and all flags 0 asynchronously. Release reset and start A=5, B=9 -> A_lt_B=1, latency 4.
6. Assert start in the done cycle with new operands A=0x0000, B=0x1000 -> accepted, done after 1 edge, A_lt_B=1. Previous flags held until that done.
